// File: rtl/mips_instr_encoder_loader_if.sv
// Request stream carrying one symbolic MIPS instruction per handshake.
// The producer (master) drives the fields and in_valid; the loader (slave) drives in_ready.
interface mips_instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output in_ready
    );
endinterface

// File: rtl/mips_instr_encoder_loader.sv
// Encodes symbolic MIPS requests into 32-bit words and writes them sequentially
// into instruction memory, holding the CPU in reset while an image is loading.
module mips_instr_encoder_loader #(
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int BASE_ADDR       = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    mips_instr_encoder_loader_if.slave req_if,
    output logic                       o_imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]                o_imem_wdata,
    output logic [IMEM_ADDR_WIDTH:0]   o_word_count,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic                       o_cpu_hold
);
    localparam logic [IMEM_ADDR_WIDTH-1:0] LP_BASE = IMEM_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IMEM_ADDR_WIDTH-1:0] LP_TOP  = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_ERROR} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_we;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]                r_wdata;
    logic [IMEM_ADDR_WIDTH:0]   r_count;
    logic                       r_done;
    logic                       r_err;

    logic                       w_ready;
    logic                       w_accept;
    logic                       w_legal;
    logic                       w_write;
    logic                       w_atTop;
    logic [31:0]                w_enc;
    logic [IMEM_ADDR_WIDTH-1:0] w_wrAddr;

    // A pending write still owns r_addr, so the next word lands one slot further on.
    assign w_ready  = (r_state == S_LOAD) && !i_start;
    assign w_accept = w_ready && req_if.in_valid;
    assign w_write  = w_accept && w_legal;
    assign w_wrAddr = r_addr + IMEM_ADDR_WIDTH'(r_we);
    assign w_atTop  = (w_wrAddr == LP_TOP);

    // Translate the symbolic request into its 32-bit machine word and flag unknown ops.
    always_comb begin
        w_legal = 1'b1;
        w_enc   = 32'h0;
        case (req_if.in_op)
            4'd0:  w_enc = {6'b000000, req_if.in_rs, req_if.in_rt, req_if.in_rd, 5'b00000, 6'b100000};
            4'd1:  w_enc = {6'b000000, req_if.in_rs, req_if.in_rt, req_if.in_rd, 5'b00000, 6'b100100};
            4'd2:  w_enc = {6'b000000, req_if.in_rs, req_if.in_rt, req_if.in_rd, 5'b00000, 6'b100101};
            4'd3:  w_enc = {6'b000000, req_if.in_rs, req_if.in_rt, req_if.in_rd, 5'b00000, 6'b100010};
            4'd4:  w_enc = {6'b000000, 5'b00000, req_if.in_rt, req_if.in_rd, req_if.in_shamt, 6'b000000};
            4'd5:  w_enc = {6'b100011, req_if.in_rs, req_if.in_rt, req_if.in_imm};
            4'd6:  w_enc = {6'b101011, req_if.in_rs, req_if.in_rt, req_if.in_imm};
            4'd7:  w_enc = {6'b001000, req_if.in_rs, req_if.in_rt, req_if.in_imm};
            4'd8:  w_enc = {6'b001100, req_if.in_rs, req_if.in_rt, req_if.in_imm};
            4'd9:  w_enc = {6'b000100, req_if.in_rs, req_if.in_rt, req_if.in_imm};
            4'd10: w_enc = {6'b000010, req_if.in_target};
            4'd11: w_enc = 32'h0;
            default: w_legal = 1'b0;
        endcase
    end

    // Load-sequence state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: start always wins; an accepted word decides between carrying on, finishing or aborting.
    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            w_next = S_ERROR;
                        end else if (req_if.in_last) begin
                            w_next = S_FLUSH;
                        end else if (w_atTop) begin
                            w_next = S_ERROR;
                        end
                    end
                end
                S_FLUSH: w_next = S_IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    // Registered memory write port, address pointer, word counter and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= LP_BASE;
            r_wdata <= 32'h0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we  <= w_write;
            r_err <= (w_next == S_ERROR);
            if (w_write) begin
                r_wdata <= w_enc;
            end
            if (i_start) begin
                r_addr  <= LP_BASE;
                r_count <= '0;
                r_done  <= 1'b0;
            end else begin
                if (r_we && (r_addr != LP_TOP)) begin
                    r_addr <= r_addr + IMEM_ADDR_WIDTH'(1);
                end
                if (w_write) begin
                    r_count <= r_count + (IMEM_ADDR_WIDTH+1)'(1);
                end
                if (r_state == S_FLUSH) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign req_if.in_ready = w_ready;
    assign o_imem_we       = r_we;
    assign o_imem_addr     = r_addr;
    assign o_imem_wdata    = r_wdata;
    assign o_word_count    = r_count;
    assign o_busy          = (r_state != S_IDLE);
    assign o_cpu_hold      = (r_state != S_IDLE);
    assign o_done          = r_done;
    assign o_err           = r_err;
endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Self-checking bench for the MIPS instruction encoder/loader: a full-size instance
// and a 4-word instance share clock and reset.
module tb_mips_instr_encoder_loader;
    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
    } req_t;

    typedef struct packed {
        req_t        req;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;

    logic        we1, busy1, done1, err1, hold1;
    logic [7:0]  addr1;
    logic [31:0] wdata1;
    logic [8:0]  count1;

    logic        we2, busy2, done2, err2, hold2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int nCompared = 0;
    int nMismatch = 0;
    int cycle = 0;
    wr_t cap1[$];
    wr_t cap2[$];

    mips_instr_encoder_loader_if bus1();
    mips_instr_encoder_loader_if bus2();

    mips_instr_encoder_loader #(.IMEM_ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .req_if(bus1),
        .o_imem_we(we1), .o_imem_addr(addr1), .o_imem_wdata(wdata1), .o_word_count(count1),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_cpu_hold(hold1)
    );

    mips_instr_encoder_loader #(.IMEM_ADDR_WIDTH(2), .BASE_ADDR(0)) dutSmall (
        .clk(clk), .rst_n(rst_n), .i_start(start2), .req_if(bus2),
        .o_imem_we(we2), .o_imem_addr(addr2), .o_imem_wdata(wdata2), .o_word_count(count2),
        .o_busy(busy2), .o_done(done2), .o_err(err2), .o_cpu_hold(hold2)
    );

    // Free-running clock and cycle counter used to timestamp writes.
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Record every memory write of both instances, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (rst_n && we1) begin
            w.addr = int'(addr1); w.data = wdata1; w.cyc = cycle;
            cap1.push_back(w);
        end
        if (rst_n && we2) begin
            w.addr = int'(addr2); w.data = wdata2; w.cyc = cycle;
            cap2.push_back(w);
        end
    end

    // Reference encoder built from the instruction table with plain arithmetic.
    function automatic logic [31:0] refEncode(input req_t r);
        int opcodeOf [12];
        int functOf [12];
        longint v;
        opcodeOf = '{0, 0, 0, 0, 0, 35, 43, 8, 12, 4, 2, 0};
        functOf  = '{32, 36, 37, 34, 0, 0, 0, 0, 0, 0, 0, 0};
        v = 0;
        if (r.op <= 3) begin
            v = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048 + functOf[r.op];
        end else if (r.op == 4) begin
            v = longint'(r.rt) * 65536 + longint'(r.rd) * 2048 + longint'(r.shamt) * 64;
        end else if (r.op <= 9) begin
            v = longint'(opcodeOf[r.op]) * 67108864 + longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.imm);
        end else if (r.op == 10) begin
            v = longint'(opcodeOf[r.op]) * 67108864 + longint'(r.target);
        end
        return v[31:0];
    endfunction

    function automatic req_t mkReq(input int op, input int rs, input int rt, input int rd,
                                   input int shamt, input int imm, input int target, input bit last);
        req_t r;
        r.op = 4'(op); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.shamt = 5'(shamt);
        r.imm = 16'(imm); r.target = 26'(target); r.last = last;
        return r;
    endfunction

    function automatic req_t randReq(input int op, input bit last);
        req_t r;
        r.op = 4'(op); r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
        r.shamt = 5'($urandom); r.imm = 16'($urandom); r.target = 26'($urandom); r.last = last;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input int which, input req_t r, input logic v);
        if (which == 1) begin
            bus1.in_valid = v; bus1.in_op = r.op; bus1.in_rs = r.rs; bus1.in_rt = r.rt; bus1.in_rd = r.rd;
            bus1.in_shamt = r.shamt; bus1.in_imm = r.imm; bus1.in_target = r.target; bus1.in_last = r.last;
        end else begin
            bus2.in_valid = v; bus2.in_op = r.op; bus2.in_rs = r.rs; bus2.in_rt = r.rt; bus2.in_rd = r.rd;
            bus2.in_shamt = r.shamt; bus2.in_imm = r.imm; bus2.in_target = r.target; bus2.in_last = r.last;
        end
    endtask

    task automatic idle(input int which);
        driveReq(which, '0, 1'b0);
    endtask

    // Present one request from a falling edge and hold it until accepted or the budget runs out.
    task automatic applyStimulus(input int which, input req_t r, input int budget, output bit accepted);
        logic rdy;
        accepted = 1'b0;
        driveReq(which, r, 1'b1);
        for (int c = 0; c < budget && !accepted; c++) begin
            #1;
            rdy = (which == 1) ? bus1.in_ready : bus2.in_ready;
            if (rdy) accepted = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic startLoad(input int which);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        if (which == 1) begin start1 = 1'b0; cap1.delete(); end
        else begin start2 = 1'b0; cap2.delete(); end
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        vec_t vecs [12];
        req_t img[$];
        logic [31:0] expWords[$];
        bit acc;
        int accCount;
        int len, badAt, nExp, gap;

        idle(1);
        idle(2);

        // Reset values while rst_n is held low.
        #3;
        checkOutput("rst_we", we1, 0);
        checkOutput("rst_addr", addr1, 0);
        checkOutput("rst_wdata", wdata1, 0);
        checkOutput("rst_count", count1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_err", err1, 0);
        checkOutput("rst_hold", hold1, 0);
        checkOutput("rst_ready", bus1.in_ready, 0);
        checkOutput("rst_small_busy", busy2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", bus1.in_ready, 0);

        // Single ADD as a one-word image: write one cycle after accept, then done.
        startLoad(1);
        #1;
        checkOutput("load_ready", bus1.in_ready, 1);
        checkOutput("load_hold", hold1, 1);
        applyStimulus(1, mkReq(0, 1, 2, 3, 0, 0, 0, 1), 5, acc);
        idle(1);
        checkOutput("add_acc", acc, 1);
        checkOutput("add_we", we1, 1);
        checkOutput("add_addr", addr1, 0);
        checkOutput("add_wdata", wdata1, 32'h00221820);
        checkOutput("add_count", count1, 1);
        checkOutput("add_hold_flush", hold1, 1);
        @(negedge clk);
        checkOutput("add_done", done1, 1);
        checkOutput("add_we_off", we1, 0);
        checkOutput("add_hold_off", hold1, 0);
        checkOutput("add_busy_off", busy1, 0);
        checkOutput("add_err", err1, 0);
        checkOutput("add_count_keep", count1, 1);

        // Table of every op with hand-encoded words, streamed back to back.
        vecs[0]  = '{mkReq(1, 3, 4, 5, 0, 0, 0, 0),        32'h00642824};
        vecs[1]  = '{mkReq(2, 7, 8, 9, 0, 0, 0, 0),        32'h00E84825};
        vecs[2]  = '{mkReq(3, 31, 1, 2, 0, 0, 0, 0),       32'h03E11022};
        vecs[3]  = '{mkReq(6, 29, 31, 0, 0, 16, 0, 0),     32'hAFBF0010};
        vecs[4]  = '{mkReq(7, 0, 1, 0, 0, 32768, 0, 0),    32'h20018000};
        vecs[5]  = '{mkReq(8, 2, 3, 0, 0, 255, 0, 0),      32'h304300FF};
        vecs[6]  = '{mkReq(11, 9, 9, 9, 9, 1234, 77, 0),   32'h00000000};
        vecs[7]  = '{mkReq(0, 1, 2, 3, 0, 0, 0, 0),        32'h00221820};
        vecs[8]  = '{mkReq(5, 0, 8, 0, 0, 4, 0, 0),        32'h8C080004};
        vecs[9]  = '{mkReq(4, 0, 2, 4, 3, 0, 0, 0),        32'h000220C0};
        vecs[10] = '{mkReq(9, 1, 2, 0, 0, 65535, 0, 0),    32'h1022FFFF};
        vecs[11] = '{mkReq(10, 0, 0, 0, 0, 0, 256, 1),     32'h08000100};
        startLoad(1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, vecs[i].req, 5, acc);
            checkOutput($sformatf("tbl_acc%0d", i), acc, 1);
        end
        idle(1);
        repeat (2) @(negedge clk);
        checkOutput("tbl_size", cap1.size(), 12);
        for (int i = 0; i < 12 && i < cap1.size(); i++) begin
            checkOutput($sformatf("tbl_addr%0d", i), cap1[i].addr, i);
            checkOutput($sformatf("tbl_word%0d", i), cap1[i].data, vecs[i].word);
            checkOutput($sformatf("tbl_cyc%0d", i), cap1[i].cyc - cap1[0].cyc, i);
        end
        checkOutput("tbl_count", count1, 12);
        checkOutput("tbl_done", done1, 1);
        checkOutput("tbl_hold", hold1, 0);

        // Random images with random valid gaps, some aborted by an illegal op.
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, 20);
            badAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            img.delete();
            expWords.delete();
            for (int i = 0; i < len; i++) begin
                img.push_back(randReq((i == badAt) ? $urandom_range(12, 15) : $urandom_range(0, 11), i == len - 1));
            end
            nExp = (badAt >= 0) ? badAt : len;
            for (int i = 0; i < nExp; i++) expWords.push_back(refEncode(img[i]));
            startLoad(1);
            for (int i = 0; i < len; i++) begin
                idle(1);
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
                applyStimulus(1, img[i], 5, acc);
                checkOutput($sformatf("rnd%0d_acc%0d", n, i), acc, 1);
                if (i == badAt) break;
            end
            idle(1);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("rnd%0d_size", n), cap1.size(), nExp);
            for (int i = 0; i < nExp && i < cap1.size(); i++) begin
                checkOutput($sformatf("rnd%0d_addr%0d", n, i), cap1[i].addr, i);
                checkOutput($sformatf("rnd%0d_word%0d", n, i), cap1[i].data, expWords[i]);
            end
            checkOutput($sformatf("rnd%0d_count", n), count1, nExp);
            checkOutput($sformatf("rnd%0d_done", n), done1, (badAt < 0));
            checkOutput($sformatf("rnd%0d_err", n), err1, (badAt >= 0));
            checkOutput($sformatf("rnd%0d_hold", n), hold1, (badAt >= 0));
        end

        // Illegal op 13 as the second word: first word only, ERROR holds until start.
        startLoad(1);
        applyStimulus(1, mkReq(0, 1, 2, 3, 0, 0, 0, 0), 5, acc);
        applyStimulus(1, mkReq(13, 1, 2, 3, 0, 0, 0, 0), 5, acc);
        checkOutput("ill_acc", acc, 1);
        repeat (3) @(negedge clk);
        idle(1);
        #1;
        checkOutput("ill_size", cap1.size(), 1);
        checkOutput("ill_err", err1, 1);
        checkOutput("ill_ready", bus1.in_ready, 0);
        checkOutput("ill_hold", hold1, 1);
        checkOutput("ill_count", count1, 1);
        @(negedge clk);
        startLoad(1);
        #1;
        checkOutput("ill_err_clear", err1, 0);
        checkOutput("ill_ready_back", bus1.in_ready, 1);

        // Start while a write is pending: that write issues, nothing accepted, restart at base.
        @(negedge clk);
        startLoad(1);
        applyStimulus(1, mkReq(7, 4, 5, 0, 0, 100, 0, 0), 5, acc);
        applyStimulus(1, mkReq(9, 6, 7, 0, 0, 200, 0, 0), 5, acc);
        start1 = 1'b1;
        driveReq(1, mkReq(5, 1, 1, 0, 0, 8, 0, 1), 1'b1);
        #1;
        checkOutput("mid_ready", bus1.in_ready, 0);
        checkOutput("mid_pend_we", we1, 1);
        checkOutput("mid_pend_addr", addr1, 1);
        checkOutput("mid_pend_word", wdata1, 32'h10C700C8);
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("mid_no_write", we1, 0);
        checkOutput("mid_count", count1, 0);
        checkOutput("mid_addr", addr1, 0);
        applyStimulus(1, mkReq(5, 1, 1, 0, 0, 8, 0, 1), 5, acc);
        idle(1);
        checkOutput("mid_acc", acc, 1);
        checkOutput("mid_new_we", we1, 1);
        checkOutput("mid_new_addr", addr1, 0);
        checkOutput("mid_new_word", wdata1, 32'h8C210008);
        checkOutput("mid_new_count", count1, 1);
        repeat (2) @(negedge clk);

        // Four-word memory fed five words without in_last: truncation error, no wrap.
        startLoad(2);
        img.delete();
        accCount = 0;
        for (int i = 0; i < 5; i++) begin
            img.push_back(randReq($urandom_range(0, 11), 1'b0));
            applyStimulus(2, img[i], 4, acc);
            if (acc) accCount++;
        end
        idle(2);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("ovf_accepts", accCount, 4);
        checkOutput("ovf_size", cap2.size(), 4);
        for (int i = 0; i < 4 && i < cap2.size(); i++) begin
            checkOutput($sformatf("ovf_addr%0d", i), cap2[i].addr, i);
            checkOutput($sformatf("ovf_word%0d", i), cap2[i].data, refEncode(img[i]));
        end
        checkOutput("ovf_err", err2, 1);
        checkOutput("ovf_done", done2, 0);
        checkOutput("ovf_count", count2, 4);
        checkOutput("ovf_ready", bus2.in_ready, 0);
        checkOutput("ovf_hold", hold2, 1);

        // Asynchronous reset in the middle of a load.
        @(negedge clk);
        startLoad(1);
        applyStimulus(1, mkReq(0, 1, 2, 3, 0, 0, 0, 0), 5, acc);
        checkOutput("arst_pre_we", we1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", we1, 0);
        checkOutput("arst_busy", busy1, 0);
        checkOutput("arst_hold", hold1, 0);
        checkOutput("arst_count", count1, 0);
        checkOutput("arst_addr", addr1, 0);
        checkOutput("arst_ready", bus1.in_ready, 0);
        checkOutput("arst_small_err", err2, 0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
